// File: rtl/adc_seq_pkg.sv
// Shared widths and FSM state encoding for the ADC scan sequencer.
package adc_seq_pkg;
  localparam int CH_W     = 4;
  localparam int SAMPLE_W = 12;
  localparam int OUT_W    = CH_W + SAMPLE_W;
  localparam int OVR_W    = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_CONVERT = 3'd3;
  localparam logic [2:0] ST_EMIT    = 3'd4;
endpackage

// File: rtl/adc_seq_tick_gen.sv
// Sweep period counter: one-cycle tick every period+1 cycles while enabled.
// Registered count, combinational tick; no backpressure (ticks are never stalled).
module adc_seq_tick_gen #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);
  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q >= period) begin
      // >= so a period lowered below the running count still wraps at once
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/adc_sequencer.sv
// Periodic ascending sweep of enabled ADC channels; tick->conv_start 2 cycles, conv_done->out_valid 1 cycle.
// Result held in EMIT until out_ready; ticks arriving mid-sweep are dropped and counted as overrun.
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH   = 16,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clear_status,
  output logic                conv_start,
  output logic [CH_W-1:0]     conv_channel,
  input  logic                conv_done,
  input  logic [SAMPLE_W-1:0] conv_sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                busy,
  output logic [OVR_W-1:0]    overrun_count,
  output logic                timeout_err
);
  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic                rst_sync_q;
  logic                tick;
  logic                more_work;
  logic [2:0]          state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [OUT_W-1:0]    data_q, data_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [OVR_W-1:0]    ovr_q, ovr_d;
  logic                err_q, err_d;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CH_W'(i);
    end
  endfunction

  // Reset asserts asynchronously but releases one clock after the pin deasserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  adc_seq_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_sync_q),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

  // Dropping enable mid-sweep abandons whatever is still pending.
  assign more_work = (pending_q != '0) && enable;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ch_d      = ch_q;
    data_d    = data_q;
    tmo_d     = tmo_q;
    ovr_d     = ovr_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (tick && (ch_mask != '0)) begin
          pending_d = ch_mask;
          state_d   = ST_SELECT;
        end
      end
      ST_SELECT: begin
        ch_d      = lowest_set(pending_q);
        pending_d = pending_q & (pending_q - NUM_CH'(1));
        state_d   = ST_START;
      end
      ST_START: begin
        tmo_d   = '0;
        state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (conv_done) begin
          data_d  = {ch_q, conv_sample};
          state_d = ST_EMIT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = more_work ? ST_SELECT : ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_EMIT: begin
        if (out_ready) state_d = more_work ? ST_SELECT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tick && (state_q != ST_IDLE) && (ovr_q != '1)) ovr_d = ovr_q + OVR_W'(1);
    if (clear_status) begin
      ovr_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      ch_q      <= '0;
      data_q    <= '0;
      tmo_q     <= '0;
      ovr_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
      err_q     <= err_d;
    end
  end

  assign conv_start    = (state_q == ST_START);
  assign conv_channel  = ch_q;
  assign out_valid     = (state_q == ST_EMIT);
  assign out_data      = data_q;
  assign busy          = (state_q != ST_IDLE);
  assign overrun_count = ovr_q;
  assign timeout_err   = err_q;
endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer with an ADC responder model and channel/data scoreboards.
module tb_adc_sequencer;
  localparam int W_START = 0, W_VALID = 1, W_IDLE = 2, W_TMO = 3, W_HS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] ch_mask = '0;
  logic [15:0] period = '0;
  logic        clear_status = 1'b0;
  logic        conv_start;
  logic [3:0]  conv_channel;
  logic        conv_done = 1'b0;
  logic [11:0] conv_sample = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        busy;
  logic [7:0]  overrun_count;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int adc_lat = 20;
  bit adc_never = 1'b0;
  bit sb_on = 1'b1;
  logic [3:0]  exp_ch[$];
  logic [15:0] exp_dat[$];

  adc_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .period(period),
    .clear_status(clear_status), .conv_start(conv_start), .conv_channel(conv_channel),
    .conv_done(conv_done), .conv_sample(conv_sample), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .overrun_count(overrun_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC responder: sample = channel*0x111, done driven in the adc_lat-th cycle after conv_start.
  always begin
    logic [3:0] ch;
    @(negedge clk);
    if (conv_start && !adc_never) begin
      ch = conv_channel;
      repeat (adc_lat - 1) @(negedge clk);
      #1;
      conv_done   = 1'b1;
      conv_sample = 12'(ch * 12'h111);
      @(negedge clk);
      #1;
      conv_done   = 1'b0;
      conv_sample = '0;
    end
  end

  // Scoreboard monitor: channel order on every conv_start, data on every accepted result.
  always begin
    @(negedge clk);
    #1;
    if (sb_on && conv_start) begin
      if (exp_ch.size() == 0) chk("start_unexpected", 32'(exp_ch.size()), 32'd1);
      else                    chk("conv_channel", 32'(conv_channel), 32'(exp_ch.pop_front()));
    end
    if (sb_on && out_valid && out_ready) begin
      hs_cnt++;
      if (exp_dat.size() == 0) chk("out_unexpected", 32'(exp_dat.size()), 32'd1);
      else                     chk("out_data", 32'(out_data), 32'(exp_dat.pop_front()));
    end
  end

  task automatic wait_for(input int sel, input int maxc, input string tag, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < maxc) begin
      @(negedge clk);
      n++;
      case (sel)
        W_START: hit = conv_start;
        W_VALID: hit = out_valid;
        W_IDLE:  hit = !busy;
        W_TMO:   hit = timeout_err;
        W_HS:    hit = out_valid && out_ready;
        default: hit = 1'b1;
      endcase
    end
    if (!hit) chk({tag, "_wait"}, 32'(hit), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_conv_start"}, 32'(conv_start), 32'd0);
    chk({tag, "_conv_channel"}, 32'(conv_channel), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun_count), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int n, t0, t1, hs0, bad, starts;

    // Reset values
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Empty mask: ticks are ignored and not counted as overrun
    period = 16'd4; ch_mask = 16'h0000; enable = 1'b1;
    bad = 0;
    repeat (30) begin @(negedge clk); if (busy) bad++; end
    chk("mask0_busy_cycles", 32'(bad), 32'd0);
    chk("mask0_overrun", 32'(overrun_count), 32'd0);
    enable = 1'b0;
    @(negedge clk);

    // Sweep of channels 0 and 2; mask change mid-sweep applies to the next sweep only
    exp_ch.push_back(4'd0); exp_ch.push_back(4'd2); exp_ch.push_back(4'd4);
    exp_dat.push_back(16'h0000); exp_dat.push_back(16'h2222); exp_dat.push_back(16'h4444);
    period = 16'd99; ch_mask = 16'h0005; out_ready = 1'b1; hs0 = hs_cnt;
    enable = 1'b1;
    wait_for(W_START, 200, "t1_start0", n);
    t0 = cyc;
    ch_mask = 16'h0010;
    wait_for(W_VALID, 100, "t1_valid0", n);
    chk("t1_start_to_valid", 32'(n), 32'd20);
    wait_for(W_START, 100, "t1_start2", n);
    wait_for(W_IDLE, 100, "t1_idle", n);
    chk("t1_hs_before_idle", 32'(hs_cnt - hs0), 32'd2);
    wait_for(W_START, 200, "t1_sweep2", n);
    t1 = cyc;
    chk("t1_sweep_interval", 32'(t1 - t0), 32'd100);
    enable = 1'b0;
    wait_for(W_IDLE, 100, "t1_end", n);
    chk("t1_ch_left", 32'(exp_ch.size()), 32'd0);
    chk("t1_dat_left", 32'(exp_dat.size()), 32'd0);

    // Backpressure: result held 50 cycles, channel 15 starts only after the accept
    exp_ch.push_back(4'd0); exp_ch.push_back(4'd15);
    exp_dat.push_back(16'h0000); exp_dat.push_back(16'hFFFF);
    period = 16'd199; ch_mask = 16'h8001; out_ready = 1'b0;
    enable = 1'b1;
    wait_for(W_VALID, 300, "t2_valid", n);
    bad = 0;
    repeat (50) begin
      if (!(out_valid === 1'b1 && out_data === 16'h0000 && conv_start === 1'b0)) bad++;
      @(negedge clk);
    end
    chk("t2_hold_bad_cycles", 32'(bad), 32'd0);
    out_ready = 1'b1;
    wait_for(W_START, 20, "t2_start15", n);
    chk("t2_accept_to_start", 32'(n), 32'd2);
    chk("t2_channel15", 32'(conv_channel), 32'd15);
    wait_for(W_HS, 100, "t2_hs15", n);
    enable = 1'b0;
    wait_for(W_IDLE, 50, "t2_end", n);

    // Timeout: no conv_done, flag after 255 CONVERT cycles, next tick sweeps normally
    exp_ch.push_back(4'd1); exp_ch.push_back(4'd1);
    exp_dat.push_back(16'h1111);
    adc_never = 1'b1; period = 16'd299; ch_mask = 16'h0002;
    enable = 1'b1;
    wait_for(W_START, 400, "t4_start", n);
    t0 = cyc;
    wait_for(W_TMO, 400, "t4_timeout", n);
    chk("t4_timeout_cycles", 32'(n), 32'd256);
    chk("t4_busy_after_timeout", 32'(busy), 32'd0);
    adc_never = 1'b0;
    wait_for(W_START, 400, "t4_restart", n);
    chk("t4_restart_interval", 32'(cyc - t0), 32'd300);
    wait_for(W_HS, 100, "t4_hs", n);
    enable = 1'b0;
    @(negedge clk);
    chk("t4_err_sticky", 32'(timeout_err), 32'd1);

    // Overrun: 11 dropped ticks per 44-cycle sweep at period 3, saturating at 255
    sb_on = 1'b0;
    period = 16'd3; ch_mask = 16'h0003;
    enable = 1'b1;
    wait_for(W_START, 20, "t3_start", n);
    wait_for(W_IDLE, 100, "t3_idle", n);
    chk("t3_overrun_first_sweep", 32'(overrun_count), 32'd11);
    repeat (1500) @(negedge clk);
    chk("t3_overrun_saturated", 32'(overrun_count), 32'd255);
    repeat (200) @(negedge clk);
    chk("t3_overrun_stays", 32'(overrun_count), 32'd255);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    chk("t3_clear_overrun", 32'(overrun_count), 32'd0);
    chk("t3_clear_timeout_err", 32'(timeout_err), 32'd0);
    ch_mask = 16'h0000;
    wait_for(W_IDLE, 100, "t3_end", n);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    sb_on = 1'b1;

    // Enable dropped during channel 1 conversion: channel 1 emitted, 2 and 3 discarded
    exp_ch.push_back(4'd1);
    exp_dat.push_back(16'h1111);
    period = 16'd199; ch_mask = 16'h000E;
    enable = 1'b1;
    wait_for(W_START, 300, "t5_start", n);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_for(W_HS, 50, "t5_hs", n);
    @(negedge clk);
    chk("t5_busy_after_hs", 32'(busy), 32'd0);
    starts = 0;
    repeat (60) begin @(negedge clk); if (conv_start) starts++; end
    chk("t5_extra_starts", 32'(starts), 32'd0);

    // Reset mid-CONVERT clears outputs at once; first start period+3 cycles after release
    exp_ch.push_back(4'd0);
    period = 16'd9; ch_mask = 16'h0001;
    enable = 1'b1;
    wait_for(W_START, 50, "t6_start", n);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_all_zero("t6_async");
    repeat (30) @(negedge clk);
    exp_ch.push_back(4'd0);
    exp_dat.push_back(16'h0000);
    reset = 1'b1;
    wait_for(W_START, 50, "t6_restart", n);
    chk("t6_release_to_start", 32'(n), 32'd12);
    wait_for(W_HS, 50, "t6_hs", n);
    enable = 1'b0;
    wait_for(W_IDLE, 50, "t6_end", n);
    chk("final_ch_left", 32'(exp_ch.size()), 32'd0);
    chk("final_dat_left", 32'(exp_dat.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
